// File: rtl/counter_load.sv
// N-bit up-counter with synchronous load and synchronous active-high reset.
// Priority at each rising edge: reset, then load, then increment (mod 2^N).
module counter_load #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] count
);

    logic [N-1:0] count_q;
    logic [N-1:0] count_d;

    // Next-state: load wins over increment; the carry out of the add is dropped.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else begin
            count_d = count_q + N'(1'b1);
        end
    end

    // Counter register with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_counter_load.sv
// Self-checking bench for counter_load: directed scenarios plus randomized
// stimulus checked against a modulo-arithmetic reference model.
module tb_counter_load;

    localparam int N   = 4;
    localparam int MOD = 1 << N;

    logic         clk;
    logic         reset;
    logic         load;
    logic [N-1:0] load_value;
    logic [N-1:0] count;

    int checks;
    int errors;
    int unsigned model;

    counter_load #(.N(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs (called at a falling edge), take one rising edge, advance
    // the reference model, and return at the next falling edge for sampling.
    task automatic drive_edge(input logic r, input logic l, input logic [N-1:0] v);
        reset      = r;
        load       = l;
        load_value = v;
        @(posedge clk);
        if (r)
            model = 0;
        else if (l)
            model = int'(v);
        else
            model = (model + 1) % MOD;
        @(negedge clk);
    endtask

    task automatic test_reset;
        drive_edge(1'b1, 1'b0, 4'b0000);
        checks++;
        if (count !== 4'b0000) begin
            errors++;
            $display("FAIL reset_first_edge: got %b expected %b", count, 4'b0000);
        end
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b1, 1'b0, 4'b0000);
            checks++;
            if (count !== 4'b0000) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b expected %b", i, count, 4'b0000);
            end
        end
    endtask

    task automatic test_load_hold;
        for (int i = 0; i < 5; i++) begin
            drive_edge(1'b0, 1'b1, 4'b0101);
            checks++;
            if (count !== 4'b0101) begin
                errors++;
                $display("FAIL load_hold[%0d]: got %b expected %b", i, count, 4'b0101);
            end
        end
    endtask

    task automatic test_reset_beats_load;
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b1, 1'b1, 4'b0101);
            checks++;
            if (count !== 4'b0000) begin
                errors++;
                $display("FAIL reset_beats_load[%0d]: got %b expected %b", i, count, 4'b0000);
            end
        end
    endtask

    task automatic test_count;
        logic [N-1:0] exp_v;
        drive_edge(1'b1, 1'b0, 4'b0000);
        for (int i = 1; i <= 5; i++) begin
            drive_edge(1'b0, 1'b0, 4'b1111);
            exp_v = N'(i);
            checks++;
            if (count !== exp_v) begin
                errors++;
                $display("FAIL count_up[%0d]: got %b expected %b", i, count, exp_v);
            end
        end
    endtask

    task automatic test_wrap;
        logic [N-1:0] seq [4];
        seq[0] = 4'b1110;
        seq[1] = 4'b1111;
        seq[2] = 4'b0000;
        seq[3] = 4'b0001;
        drive_edge(1'b0, 1'b1, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) drive_edge(1'b0, 1'b0, 4'b0000);
            checks++;
            if (count !== seq[i]) begin
                errors++;
                $display("FAIL wrap[%0d]: got %b expected %b", i, count, seq[i]);
            end
        end
        drive_edge(1'b0, 1'b1, 4'b1111);
        drive_edge(1'b0, 1'b0, 4'b1111);
        checks++;
        if (count !== 4'b0000) begin
            errors++;
            $display("FAIL load_max_then_wrap: got %b expected %b", count, 4'b0000);
        end
    endtask

    task automatic test_load_pulse;
        drive_edge(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 3; i++) drive_edge(1'b0, 1'b0, 4'b0000);
        checks++;
        if (count !== 4'b0011) begin
            errors++;
            $display("FAIL pulse_pre: got %b expected %b", count, 4'b0011);
        end
        drive_edge(1'b0, 1'b1, 4'b1010);
        checks++;
        if (count !== 4'b1010) begin
            errors++;
            $display("FAIL pulse_load: got %b expected %b", count, 4'b1010);
        end
        drive_edge(1'b0, 1'b0, 4'b1010);
        checks++;
        if (count !== 4'b1011) begin
            errors++;
            $display("FAIL pulse_after: got %b expected %b", count, 4'b1011);
        end
        // Reset mid-sequence, then counting resumes from zero.
        drive_edge(1'b1, 1'b0, 4'b0000);
        drive_edge(1'b0, 1'b0, 4'b0000);
        checks++;
        if (count !== 4'b0001) begin
            errors++;
            $display("FAIL resume_after_reset: got %b expected %b", count, 4'b0001);
        end
    endtask

    task automatic test_between_edges;
        logic [N-1:0] held;
        held = count;
        for (int i = 0; i < 4; i++) begin
            #1;
            reset      = 1'($urandom);
            load       = 1'($urandom);
            load_value = N'($urandom);
            #0;
            checks++;
            if (count !== held) begin
                errors++;
                $display("FAIL between_edges[%0d]: got %b expected %b", i, count, held);
            end
        end
        @(negedge clk);
        model = int'(held);
    endtask

    task automatic test_random;
        logic         r;
        logic         l;
        logic [N-1:0] v;
        drive_edge(1'b1, 1'b0, 4'b0000);
        for (int i = 0; i < 300; i++) begin
            r = ($urandom_range(0, 15) == 0);
            l = ($urandom_range(0, 3) == 0);
            v = N'($urandom);
            drive_edge(r, l, v);
            checks++;
            if (count !== N'(model)) begin
                errors++;
                $display("FAIL random[%0d]: got %b expected %b (r=%b l=%b v=%b)",
                         i, count, N'(model), r, l, v);
            end
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        model      = 0;
        reset      = 1'b1;
        load       = 1'b0;
        load_value = '0;
        @(negedge clk);
        test_reset;
        test_load_hold;
        test_reset_beats_load;
        test_count;
        test_wrap;
        test_load_pulse;
        test_between_edges;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_load.md
COUNTER_LOAD -- requirements
Module: counter_load

Interface
REQ-001 Parameter N SHALL default to 4 and set the counter width in bits (N >= 1).
REQ-002 clk SHALL be an input, 1 bit: the single clock; all state SHALL update only on its rising edge.
REQ-003 reset SHALL be an input, 1 bit: synchronous, active-high reset.
REQ-004 load SHALL be an input, 1 bit: active-high synchronous load enable.
REQ-005 load_value SHALL be an input, N bits: value captured into the counter when load is asserted.
REQ-006 count SHALL be an output, N bits: current counter value, driven directly from a register.
REQ-007 The block SHALL use one clock, and reset SHALL be synchronous and active-high; no other clocks, asynchronous resets or ports SHALL exist.

Function
REQ-008 Priority at each rising clk edge SHALL be: reset, then load, then increment.
REQ-009 If reset=1 at a rising edge, count SHALL become 0 on that edge, regardless of load and load_value.
REQ-010 If reset=0 and load=1 at a rising edge, count SHALL become load_value on that edge.
REQ-011 While load stays high, count SHALL track load_value, with one-cycle latency and no increment.
REQ-012 If reset=0 and load=0 at a rising edge, count SHALL become (count + 1) mod 2^N.
REQ-013 Wrap-around: with count = 2^N - 1 and no reset or load, the next count SHALL be 0, with no flag or saturation.
REQ-014 Loading 2^N - 1 followed by load=0 SHALL give 0 on the next edge.
REQ-015 count SHALL change only on rising clk edges; changes to inputs between edges SHALL have no effect on count until the next edge.
REQ-016 Arithmetic SHALL be unsigned, N-bit modulo; the carry out SHALL be discarded.
REQ-017 Asserting reset during a load or count sequence SHALL clear count on the next edge.
REQ-018 After reset deasserts, behaviour SHALL resume per REQ-010 or REQ-012 from the next edge.

Reset
REQ-019 count SHALL be 0 after the first rising edge with reset=1.
REQ-020 Before the first reset edge, count is unspecified; benches SHALL NOT check it.
REQ-021 Holding reset high for multiple cycles SHALL keep count at 0.

Verification (N=4, 10 ns clock)
REQ-022 Apply reset=1, load=0, load_value=0000 for one edge -> count=0000.
REQ-023 Apply reset=0, load=1, load_value=0101 and hold for 5 edges -> count=0101 after the first edge and stays 0101.
REQ-024 Apply reset=1 with load=1, load_value=0101 -> count=0000 on the next edge, and stays 0000 while reset is held (reset beats load).
REQ-025 From reset, apply reset=0, load=0 for 5 edges -> count=0001, 0010, 0011, 0100, 0101.
REQ-026 Load 1110, then load=0 for 3 edges -> count=1110, 1111, 0000, 0001 (wrap-around).
REQ-027 While counting at 0011, pulse load=1 with load_value=1010 for one edge, then load=0 -> count=1010, then 1011.
